ifu_fetch: RTL
==============

# ifu_fetch

Instruction-fetch front end that sits directly upstream of `mmu`. It sequences the fetch PC and drives the `i_req`/`i_va` request port of `mmu`. It tracks up to two outstanding requests, unpacks single or double (64-bit) responses into per-instruction entries, and buffers them in an in-order instruction queue. The queue feeds dual-issue decode and supports redirect/flush and fetch-side exception capture.

## Interface
- `RESET_PC`, default `32'h1c00_0000`: fetch address after reset.
- `QDEPTH`, default 8: instruction-queue entries, power of two, minimum 4.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch PC.
- `i_req` out 1: request to `mmu`.
- `i_va` out 32: fetch virtual address.
- `i_addr_ok` in 1: request accepted.
- `i_double` in 1: accepted request returns two instructions; sampled with `i_addr_ok`.
- `i_data_ok` in 1: response valid, in order.
- `i_rdata` in 64: `[31:0]` is the instruction at `va`; `[63:32]` is at `va+4` when double.
- `i_tlbr`, `i_pif`, `i_ppi` in 1 each: combinational translation faults for the current `i_va`.
- `out0_valid`, `out1_valid` out 1: queue head and head+1 are valid.
- `out0_pc`, `out1_pc` out 32.
- `out0_inst`, `out1_inst` out 32.
- `out0_excp`, `out1_excp` out 3: 0 none, 1 ADEF, 2 TLBR, 3 PIF, 4 PPI.
- `pop` in 2: entries consumed this cycle, 0..2. Must not exceed the valid count.

## Operation
- State:
  - `pc`.
  - `stall_excp` flag.
  - 2-entry in-flight tracker, each entry `{pc, double, discard}`.
  - Circular queue with head/tail pointers and a count.
- Request issue:
  - `i_req=1` when `!stall_excp`, tracker not full, no fault on the current `pc`, and `free_slots - 2*inflight_live >= 2`.
  - `inflight_live` counts non-discarded tracker entries.
  - `i_va = pc` always.
- Handshake on `i_req && i_addr_ok` (no redirect that cycle):
  - Push `{pc, i_double, 0}` into the tracker.
  - Advance `pc` by 8 if `i_double`, else by 4.
- Fault capture:
  - If `pc[1:0]!=0`: ADEF.
  - Else if `i_tlbr`: TLBR. Else if `i_pif`: PIF. Else if `i_ppi`: PPI.
  - On a fault, `i_req=0`. Once the tracker is empty and the queue has 1 free slot, push `{pc, 0, code}` and set `stall_excp`.
  - Priority is ADEF > TLBR > PIF > PPI.
- Response on `i_data_ok`:
  - Pop the tracker head.
  - If `discard`: drop the response.
  - Else push `{pc, rdata[31:0], 0}`.
  - If `double`, also push `{pc+4, rdata[63:32], 0}`.
- Queue: push of 0..2 entries and pop of 0..2 entries in the same cycle. `count_next = count + pushed - pop`. Pointers wrap modulo `QDEPTH`.
- Redirect, which wins over every same-cycle event:
  - Queue emptied; `pc = redirect_pc`; `stall_excp` cleared.
  - All tracker entries get `discard=1`.
  - A request handshaken in the same cycle is entered with `discard=1`.
  - A same-cycle `data_ok` is dropped.
  - `pop` is ignored.
- Discarded entries still occupy the tracker until their `data_ok` arrives. This keeps responses matched to requests in order.

## Timing
- Reset values:
  - `i_req=0`, `pc=RESET_PC`, queue empty.
  - All `outN_valid=0`.
  - `outN_pc`, `outN_inst`, `outN_excp` = 0.
  - Tracker empty; `stall_excp=0`.
- First `i_req` is asserted in the first cycle after `reset` rises.
- `i_req`/`i_va` stay stable until `i_addr_ok` or a redirect.
- `i_data_ok` arrives no earlier than the cycle after its `i_addr_ok`. A back-to-back `addr_ok` and `data_ok` in the same cycle is supported.
- Queue outputs are registered: an entry pushed at edge N is visible on `out0`/`out1` after edge N.
- Fetch-to-decode latency is therefore `addr_ok` cycle + mmu latency + 1.
- A redirect at edge N puts `i_va=redirect_pc` with `i_req` possibly high in cycle N+1.
- Full queue: `i_req` held at 0; existing reservations guarantee every live response fits.
- Empty queue: both valids 0.
- One entry: only `out0_valid` is set.

## Test plan
- Reset sequence:
  - Stimulus: reset low 3 cycles, then high; `mmu` model answers `addr_ok` immediately, `data_ok` one cycle later, `double=1`.
  - Required: `i_va` = `1c000000`, `1c000008`, …; `out0_pc=1c000000`, `out1_pc=1c000004`; `rdata` halves land in the matching slots.
- Mixed single/double:
  - Stimulus: `double=0` at `1c00003c`.
  - Required: next `i_va=1c000040`; one entry with pc `1c00003c`.
- Redirect with 2 in flight:
  - Stimulus: redirect to `1c001000` while both tracker entries are pending.
  - Required: both old responses are dropped, the queue is empty the next cycle, and the first queued pc is `1c001000`.
- Fault on the current pc:
  - Stimulus: `i_tlbr=1` at `1c002000`.
  - Required: no handshake; one entry `{1c002000, excp=2}`; `i_req` stays 0 until redirect.
  - Stimulus: `redirect_pc=1c000002`.
  - Required: one ADEF entry.
- Backpressure:
  - Stimulus: `pop=0` for 20 cycles, `QDEPTH=8`, double responses.
  - Required: exactly 8 entries, no overflow, `i_req=0`.
  - Stimulus: `pop=2` for 1 cycle.
  - Required: count drops to 6 and fetch resumes.
- Simultaneous events:
  - Stimulus: `data_ok` double, `pop=2`, count=3, same cycle.
  - Required: count becomes 3 and order is preserved.
  - Stimulus: the same cycle with redirect added.
  - Required: count becomes 0.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: drives the fetch PC toward the mmu, tracks up to two
// outstanding requests and buffers returned instructions in an in-order queue.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int unsigned QDEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        i_req,
    output logic [31:0] i_va,
    input  logic        i_addr_ok,
    input  logic        i_double,
    input  logic        i_data_ok,
    input  logic [63:0] i_rdata,
    input  logic        i_tlbr,
    input  logic        i_pif,
    input  logic        i_ppi,
    output logic        out0_valid,
    output logic        out1_valid,
    output logic [31:0] out0_pc,
    output logic [31:0] out1_pc,
    output logic [31:0] out0_inst,
    output logic [31:0] out1_inst,
    output logic [2:0]  out0_excp,
    output logic [2:0]  out1_excp,
    input  logic [1:0]  pop
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = CW + 2;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADEF = 3'd1;
    localparam logic [2:0] EXC_TLBR = 3'd2;
    localparam logic [2:0] EXC_PIF  = 3'd3;
    localparam logic [2:0] EXC_PPI  = 3'd4;

    logic [31:0]   pc_q, pc_d;
    logic          stall_q, stall_d;
    logic [31:0]   trk_pc_q [2];
    logic [1:0]    trk_dbl_q;
    logic [1:0]    trk_disc_q, trk_disc_d;
    logic          trk_rd_q, trk_rd_d;
    logic          trk_wr_q, trk_wr_d;
    logic [1:0]    trk_cnt_q, trk_cnt_d;

    logic [31:0]   q_pc_q   [QDEPTH];
    logic [31:0]   q_inst_q [QDEPTH];
    logic [2:0]    q_excp_q [QDEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [2:0]    fault_code;
    logic [1:0]    slot_vld;
    logic [1:0]    live;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] pop_ext, pop_eff;
    logic          room_ok;
    logic          hs;
    logic          data_take, data_push, excp_push;
    logic [1:0]    push_n;
    logic [31:0]   wr0_pc, wr0_inst, wr1_pc, wr1_inst;
    logic [2:0]    wr0_excp;
    logic [PW-1:0] head1;

    always_comb begin
        fault_code = EXC_NONE;
        if (pc_q[1:0] != 2'b00) fault_code = EXC_ADEF;
        else if (i_tlbr)        fault_code = EXC_TLBR;
        else if (i_pif)         fault_code = EXC_PIF;
        else if (i_ppi)         fault_code = EXC_PPI;
    end

    assign slot_vld[0] = (trk_cnt_q == 2'd2) || ((trk_cnt_q == 2'd1) && !trk_rd_q);
    assign slot_vld[1] = (trk_cnt_q == 2'd2) || ((trk_cnt_q == 2'd1) && trk_rd_q);
    assign live        = {1'b0, slot_vld[0] & ~trk_disc_q[0]} + {1'b0, slot_vld[1] & ~trk_disc_q[1]};
    assign free_slots  = CW'(QDEPTH) - count_q;
    // Every live request holds a two-slot reservation so its response always fits.
    assign room_ok     = RW'(free_slots) >= (RW'({live, 1'b0}) + RW'(2));

    assign i_req     = reset && !stall_q && (trk_cnt_q != 2'd2) && (fault_code == EXC_NONE) && room_ok;
    assign i_va      = pc_q;
    assign hs        = i_req && i_addr_ok;
    assign data_take = i_data_ok && (trk_cnt_q != 2'd0);
    assign data_push = data_take && !trk_disc_q[trk_rd_q] && !redirect_valid;
    assign excp_push = !stall_q && !redirect_valid && (fault_code != EXC_NONE)
                       && (trk_cnt_q == 2'd0) && (free_slots != '0);

    assign wr1_pc   = trk_pc_q[trk_rd_q] + 32'd4;
    assign wr1_inst = i_rdata[63:32];
    assign pop_ext  = CW'(pop);
    assign pop_eff  = (pop_ext > count_q) ? count_q : pop_ext;

    always_comb begin
        pc_d       = pc_q;
        stall_d    = stall_q;
        trk_disc_d = trk_disc_q;
        trk_rd_d   = trk_rd_q;
        trk_wr_d   = trk_wr_q;
        trk_cnt_d  = trk_cnt_q + {1'b0, hs} - {1'b0, data_take};
        push_n     = 2'd0;
        wr0_pc     = pc_q;
        wr0_inst   = 32'd0;
        wr0_excp   = fault_code;
        if (data_take) trk_rd_d = ~trk_rd_q;
        if (hs)        trk_wr_d = ~trk_wr_q;
        if (redirect_valid) begin
            trk_disc_d = 2'b11;
            pc_d       = redirect_pc;
            stall_d    = 1'b0;
        end else begin
            if (hs) pc_d = pc_q + (i_double ? 32'd8 : 32'd4);
            if (excp_push) begin
                stall_d = 1'b1;
                push_n  = 2'd1;
            end else if (data_push) begin
                push_n   = trk_dbl_q[trk_rd_q] ? 2'd2 : 2'd1;
                wr0_pc   = trk_pc_q[trk_rd_q];
                wr0_inst = i_rdata[31:0];
                wr0_excp = EXC_NONE;
            end
        end
        // A request accepted alongside a redirect belongs to the old stream.
        if (hs) trk_disc_d[trk_wr_q] = redirect_valid;
    end

    always_comb begin
        head_d  = head_q + PW'(pop_eff);
        tail_d  = tail_q + PW'(push_n);
        count_d = count_q + CW'(push_n) - pop_eff;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            stall_q    <= 1'b0;
            trk_disc_q <= 2'b00;
            trk_rd_q   <= 1'b0;
            trk_wr_q   <= 1'b0;
            trk_cnt_q  <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            stall_q    <= stall_d;
            trk_disc_q <= trk_disc_d;
            trk_rd_q   <= trk_rd_d;
            trk_wr_q   <= trk_wr_d;
            trk_cnt_q  <= trk_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: validity comes from the counters above.
    always_ff @(posedge clk) begin
        if (hs) begin
            trk_pc_q[trk_wr_q]  <= pc_q;
            trk_dbl_q[trk_wr_q] <= i_double;
        end
        if (push_n != 2'd0) begin
            q_pc_q[tail_q]   <= wr0_pc;
            q_inst_q[tail_q] <= wr0_inst;
            q_excp_q[tail_q] <= wr0_excp;
        end
        if (push_n == 2'd2) begin
            q_pc_q[tail_q + PW'(1)]   <= wr1_pc;
            q_inst_q[tail_q + PW'(1)] <= wr1_inst;
            q_excp_q[tail_q + PW'(1)] <= EXC_NONE;
        end
    end

    assign head1      = head_q + PW'(1);
    assign out0_valid = (count_q != '0);
    assign out1_valid = (count_q > CW'(1));
    assign out0_pc    = out0_valid ? q_pc_q[head_q]   : 32'd0;
    assign out0_inst  = out0_valid ? q_inst_q[head_q] : 32'd0;
    assign out0_excp  = out0_valid ? q_excp_q[head_q] : EXC_NONE;
    assign out1_pc    = out1_valid ? q_pc_q[head1]    : 32'd0;
    assign out1_inst  = out1_valid ? q_inst_q[head1]  : 32'd0;
    assign out1_excp  = out1_valid ? q_excp_q[head1]  : EXC_NONE;
endmodule
